// File: rtl/softmax_row_scheduler.sv
// Row issue/return scheduler for one attention tile: issues ROWS row requests to the
// quantize/softmax datapath, bounds rows in flight to MAX_OUT, and checks result ordering.
module softmax_row_scheduler #(
  parameter int ROWS    = 32,
  parameter int MAX_OUT = 4,
  parameter int SHIFT_W = 3,
  localparam int IDX_W  = $clog2(ROWS),
  localparam int OUT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic               o_busy,
  output logic               o_row_valid,
  output logic [IDX_W-1:0]   o_row_idx,
  output logic [SHIFT_W-1:0] o_shift,
  input  logic               i_row_ready,
  input  logic               i_res_valid,
  input  logic [IDX_W-1:0]   i_res_idx,
  output logic               o_res_ready,
  output logic [OUT_W-1:0]   o_outstanding,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   issue_idx_reg, issue_idx_next;
  logic [IDX_W-1:0]   exp_idx_reg, exp_idx_next;
  logic [OUT_W-1:0]   outstanding_reg, outstanding_next;
  logic [SHIFT_W-1:0] shift_reg, shift_next;
  logic               err_reg, err_next;

  logic busy;
  logic row_valid;
  logic issue_hs;
  logic result_hs;
  logic spurious;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      issue_idx_reg   <= '0;
      exp_idx_reg     <= '0;
      outstanding_reg <= '0;
      shift_reg       <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      issue_idx_reg   <= issue_idx_next;
      exp_idx_reg     <= exp_idx_next;
      outstanding_reg <= outstanding_next;
      shift_reg       <= shift_next;
      err_reg         <= err_next;
    end
  end

  // Valid is decoded from registered state only; outstanding never rises without a
  // handshake, so once valid is up it cannot drop before its row is accepted.
  always_comb begin
    busy      = (state_reg != IDLE);
    row_valid = (state_reg == ISSUE) && (outstanding_reg < OUT_W'(MAX_OUT));
    issue_hs  = row_valid && i_row_ready;
    result_hs = busy && i_res_valid && (outstanding_reg != '0);
    spurious  = busy && i_res_valid && (outstanding_reg == '0);
  end

  always_comb begin
    state_next       = state_reg;
    issue_idx_next   = issue_idx_reg;
    exp_idx_next     = exp_idx_reg;
    outstanding_next = outstanding_reg;
    shift_next       = shift_reg;
    err_next         = err_reg;

    if (issue_hs) begin
      issue_idx_next = issue_idx_reg + IDX_W'(1);
    end

    // A mis-tagged result still counts as returned so the tile can finish.
    if (result_hs) begin
      exp_idx_next = exp_idx_reg + IDX_W'(1);
      if (i_res_idx != exp_idx_reg) begin
        err_next = 1'b1;
      end
    end

    if (spurious) begin
      err_next = 1'b1;
    end

    case ({issue_hs, result_hs})
      2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
      2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
      default: outstanding_next = outstanding_reg;
    endcase

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          shift_next       = i_shift;
          err_next         = 1'b0;
          issue_idx_next   = '0;
          exp_idx_next     = '0;
          outstanding_next = '0;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_hs && (issue_idx_reg == IDX_W'(ROWS - 1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (result_hs && (exp_idx_reg == IDX_W'(ROWS - 1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_busy        = busy;
  assign o_row_valid   = row_valid;
  assign o_row_idx     = issue_idx_reg;
  assign o_shift       = shift_reg;
  assign o_res_ready   = busy;
  assign o_outstanding = outstanding_reg;
  assign o_done        = (state_reg == DONE);
  assign o_err         = err_reg;

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler: in-order auto responder, stalls, full window,
// mis-tagged result, mid-tile reset, spurious result and start-during-drain.
module tb_softmax_row_scheduler;
  localparam int ROWS    = 32;
  localparam int MAX_OUT = 4;
  localparam int SHIFT_W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   shift_in = '0;
  logic         row_ready = 1'b0;
  logic         man_valid = 1'b0;
  logic [4:0]   man_idx = '0;
  logic         auto_en = 1'b0;
  logic         auto_valid = 1'b0;
  logic [4:0]   auto_idx = '0;
  int           corrupt_at = -1;

  logic         res_valid;
  logic [4:0]   res_idx;
  logic         busy, row_valid, res_ready, done, err;
  logic [4:0]   row_idx;
  logic [2:0]   shift_out;
  logic [2:0]   outstanding;

  int checks = 0;
  int failures = 0;

  assign res_valid = auto_en ? auto_valid : man_valid;
  assign res_idx   = auto_en ? auto_idx : man_idx;

  softmax_row_scheduler #(.ROWS(ROWS), .MAX_OUT(MAX_OUT), .SHIFT_W(SHIFT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_shift(shift_in),
    .o_busy(busy), .o_row_valid(row_valid), .o_row_idx(row_idx), .o_shift(shift_out),
    .i_row_ready(row_ready), .i_res_valid(res_valid), .i_res_idx(res_idx),
    .o_res_ready(res_ready), .o_outstanding(outstanding), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // Monitor and responder bookkeeping: events are captured mid-cycle and acted on after the edge.
  logic [4:0] pend_idx[$];
  int         pend_due[$];
  logic [4:0] iss_log[$];
  int         cyc = 0;
  int         done_total = 0;
  int         max_seen = 0;
  logic       ev_issue = 1'b0;
  logic       ev_ret = 1'b0;
  logic [4:0] ev_idx = '0;

  always @(negedge clk) begin
    ev_issue = rst_n && row_valid && row_ready;
    ev_idx   = row_idx;
    ev_ret   = rst_n && auto_en && auto_valid && res_ready && (outstanding != 0);
    if (ev_issue) iss_log.push_back(row_idx);
    if (rst_n && done) done_total++;
    if (int'(outstanding) > max_seen) max_seen = int'(outstanding);
  end

  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      pend_idx.delete();
      pend_due.delete();
      auto_valid = 1'b0;
    end else begin
      if (ev_ret) begin
        void'(pend_idx.pop_front());
        void'(pend_due.pop_front());
      end
      if (ev_issue) begin
        pend_idx.push_back(ev_idx);
        pend_due.push_back(cyc + 3);
      end
      auto_valid = 1'b0;
      if (pend_idx.size() > 0 && pend_due[0] <= cyc + 1) begin
        auto_valid = 1'b1;
        auto_idx   = (int'(pend_idx[0]) == corrupt_at) ? pend_idx[0] + 5'd1 : pend_idx[0];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_row(input string tag, input logic [4:0] idx);
    int n = 0;
    while (!(row_valid === 1'b1 && row_idx == idx) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_row_reached"}, 32'(row_idx), 32'(idx));
  endtask

  task automatic do_start(input logic [2:0] sh);
    shift_in = sh;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int base;
    int d0;
    int bad;
    int n;

    // Reset state and no activity without a start
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'({busy, row_valid, row_idx, shift_out, res_ready, outstanding, done, err}), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_no_start_busy", 32'(busy), 32'd0);

    // A: full tile, ready always high, results in order 3 cycles after issue
    auto_en = 1'b1;
    row_ready = 1'b1;
    base = iss_log.size();
    d0 = done_total;
    do_start(3'd5);
    chk("A_first_issue", 32'({busy, res_ready, row_valid, row_idx, shift_out}), 32'({1'b1, 1'b1, 1'b1, 5'd0, 3'd5}));
    wait_done("A");
    chk("A_err_at_done", 32'(err), 32'd0);
    tick();
    chk("A_done_one_cycle", 32'({done, busy}), 32'd0);
    chk("A_issue_count", 32'(iss_log.size() - base), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) if (int'(iss_log[base + i]) != i) bad++;
    chk("A_issue_order_errors", 32'(bad), 32'd0);
    chk("A_max_outstanding_le4", 32'(max_seen <= 4), 32'd1);
    chk("A_done_pulses", 32'(done_total - d0), 32'd1);

    // B: stall the datapath at row 7 for 5 cycles
    do_start(3'd5);
    wait_row("B", 5'd7);
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("B_stall_valid", 32'(row_valid), 32'd1);
      chk("B_stall_idx", 32'(row_idx), 32'd7);
    end
    row_ready = 1'b1;
    tick();
    chk("B_resume_idx", 32'(row_idx), 32'd8);
    wait_done("B");
    chk("B_err_at_done", 32'(err), 32'd0);
    tick();

    // C: withhold results until the window is full, then return one
    auto_en = 1'b0;
    do_start(3'd1);
    n = 0;
    while (outstanding != 3'd4 && n < 50) begin
      tick();
      n++;
    end
    chk("C_full_outstanding", 32'(outstanding), 32'd4);
    chk("C_full_valid_low", 32'({row_valid, row_idx}), 32'({1'b0, 5'd4}));
    tick();
    chk("C_full_hold", 32'({row_valid, outstanding}), 32'({1'b0, 3'd4}));
    man_valid = 1'b1;
    man_idx = 5'd0;
    tick();
    man_valid = 1'b0;
    chk("C_after_result", 32'({row_valid, row_idx, outstanding}), 32'({1'b1, 5'd4, 3'd3}));
    tick();
    chk("C_reissue", 32'({row_idx, outstanding, err}), 32'({5'd5, 3'd4, 1'b0}));
    rst_n = 1'b0;
    #1;
    chk("C_reset_outputs", 32'({busy, row_valid, row_idx, shift_out, res_ready, outstanding, done, err}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // D: result tagged 5 while 4 is expected
    auto_en = 1'b1;
    corrupt_at = 4;
    do_start(3'd4);
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("D_err_set", 32'(err), 32'd1);
    wait_done("D");
    chk("D_err_at_done", 32'(err), 32'd1);
    tick();
    chk("D_err_sticky_idle", 32'({busy, err}), 32'({1'b0, 1'b1}));
    corrupt_at = -1;

    // E: next start clears err; reset mid-tile at row 12
    do_start(3'd2);
    chk("E_start_clears_err", 32'({err, shift_out}), 32'({1'b0, 3'd2}));
    wait_row("E", 5'd12);
    rst_n = 1'b0;
    #1;
    chk("E_reset_async", 32'({busy, row_valid, row_idx, shift_out, res_ready, outstanding, done, err}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("E_no_resume", 32'({busy, row_valid, row_idx}), 32'd0);
    do_start(3'd6);
    chk("E_restart", 32'({busy, row_valid, row_idx, shift_out}), 32'({1'b1, 1'b1, 5'd0, 3'd6}));
    wait_done("E");
    chk("E_err_at_done", 32'(err), 32'd0);
    tick();

    // F: spurious result with nothing outstanding, then a start during DRAIN
    auto_en = 1'b0;
    row_ready = 1'b0;
    do_start(3'd3);
    man_valid = 1'b1;
    man_idx = 5'd0;
    tick();
    man_valid = 1'b0;
    chk("F_spurious_err", 32'(err), 32'd1);
    chk("F_spurious_counters", 32'({row_idx, outstanding, row_valid}), 32'({5'd0, 3'd0, 1'b1}));
    auto_en = 1'b1;
    row_ready = 1'b1;
    wait_row("F", 5'd31);
    tick();
    chk("F_in_drain", 32'({busy, row_valid}), 32'({1'b1, 1'b0}));
    shift_in = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("F_start_ignored", 32'({busy, shift_out}), 32'({1'b1, 3'd3}));
    wait_done("F");
    chk("F_err_sticky_done", 32'(err), 32'd1);
    tick();
    tick();
    chk("F_idle_after", 32'({busy, shift_out}), 32'({1'b0, 3'd3}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
